// File: rtl/alu_arbiter_if.sv
// Request/response bundle for the two-port ALU arbiter.
// Master side issues ops and drains responses; slave is the arbiter.
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [2:0] req0_op;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [2:0] req1_op;
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [7:0] rsp_f;
  logic       rsp_ovf;
  logic       rsp_br;
  logic       busy;
  logic       grant_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp_f, rsp_ovf, rsp_br, busy, grant_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp_f, rsp_ovf, rsp_br, busy, grant_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 8-bit ALU between two requesters.
// IDLE -> EXEC -> RESP; responses are registered and op-normalised.
module alu_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input logic        clk,
  input logic        rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, nxt;
  logic [7:0] a_q, b_q;
  logic [2:0] op_q;
  logic       gid_q;
  logic       last_q;
  logic [7:0] f_q;
  logic       ovf_q, br_q;

  logic       win;
  logic       acc;
  logic       done;
  logic       r0, r1, rv0, rv1;
  logic [8:0] sum;
  logic [7:0] alu_f;
  logic       alu_ovf, alu_br;

  // Winner: the port that did not win last time when both are valid.
  assign win = (bus.req0_valid && bus.req1_valid) ? ~last_q
                                                  : ~bus.req0_valid;

  // Shared ALU, outputs forced to zero where an op leaves them undefined.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    alu_f   = 8'h00;
    alu_ovf = 1'b0;
    alu_br  = 1'b0;
    unique case (op_q)
      3'b000: begin
        alu_f   = sum[7:0];
        alu_ovf = sum[8];
      end
      3'b001: alu_f = ~b_q;
      3'b010: alu_f = a_q & b_q;
      3'b011: alu_f = a_q | b_q;
      3'b100: alu_f = {1'b0, a_q[7:1]};
      3'b101: alu_f = {a_q[6:0], 1'b0};
      3'b110: alu_br = (a_q == b_q);
      3'b111: alu_br = (a_q != b_q);
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    nxt  = state;
    r0   = 1'b0;
    r1   = 1'b0;
    rv0  = 1'b0;
    rv1  = 1'b0;
    acc  = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          r0  = ~win;
          r1  = win;
          acc = 1'b1;
          nxt = EXEC;
        end
      end
      EXEC: nxt = RESP;
      RESP: begin
        rv0  = ~gid_q;
        rv1  = gid_q;
        done = gid_q ? bus.rsp1_ready : bus.rsp0_ready;
        if (done) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Operand capture, result registration and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      op_q   <= 3'b000;
      gid_q  <= RR_INIT;
      last_q <= ~RR_INIT;
      f_q    <= 8'h00;
      ovf_q  <= 1'b0;
      br_q   <= 1'b0;
    end else begin
      if (acc) begin
        gid_q <= win;
        a_q   <= win ? bus.req1_a  : bus.req0_a;
        b_q   <= win ? bus.req1_b  : bus.req0_b;
        op_q  <= win ? bus.req1_op : bus.req0_op;
      end
      if (state == EXEC) begin
        f_q   <= alu_f;
        ovf_q <= alu_ovf;
        br_q  <= alu_br;
      end
      if (done) last_q <= gid_q;
    end
  end

  assign bus.req0_ready = r0;
  assign bus.req1_ready = r1;
  assign bus.rsp0_valid = rv0;
  assign bus.rsp1_valid = rv1;
  assign bus.rsp_f      = f_q;
  assign bus.rsp_ovf    = ovf_q;
  assign bus.rsp_br     = br_q;
  assign bus.busy       = (state != IDLE);
  assign bus.grant_id   = gid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed ops, arbitration,
// backpressure and reset-during-response.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_arbiter_if bus ();

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         p;
    logic [7:0] f;
    logic       o;
    logic       b;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every completed response.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp0_valid || bus.rsp1_valid)
        chk("one_rsp_valid", {31'd0, bus.rsp0_valid & bus.rsp1_valid}, 0);
      if (bus.req0_ready || bus.req1_ready)
        chk("one_req_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 0);
      if ((bus.rsp0_valid && bus.rsp0_ready) ||
          (bus.rsp1_valid && bus.rsp1_ready)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got response, expected none");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_port", {31'd0, bus.rsp1_valid}, {31'd0, e.p});
          chk("rsp_f", {24'd0, bus.rsp_f}, {24'd0, e.f});
          chk("rsp_ovf", {31'd0, bus.rsp_ovf}, {31'd0, e.o});
          chk("rsp_br", {31'd0, bus.rsp_br}, {31'd0, e.b});
          chk("grant_id", {31'd0, bus.grant_id}, {31'd0, e.p});
        end
      end
    end
  end

  task automatic push(input bit p, input logic [7:0] f,
                      input logic o, input logic b);
    exp_t e;
    e.p = p;
    e.f = f;
    e.o = o;
    e.b = b;
    q.push_back(e);
  endtask

  task automatic drive(input bit p, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] op);
    if (p) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
      bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
      bus.req0_valid = 1'b1;
    end
  endtask

  // Issue one op, push its expectation on acceptance; returns at T+1 #1.
  task automatic issue(input bit p, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] op,
                       input logic [7:0] ef, input logic eo,
                       input logic eb);
    bit ok = 1'b0;
    drive(p, a, b, op);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (p ? bus.req1_ready : bus.req0_ready) begin
        ok = 1'b1;
        push(p, ef, eo, eb);
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: port %0d never accepted", p);
    end
    @(posedge clk);
    #1;
    if (p) bus.req1_valid = 1'b0;
    else   bus.req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit p);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (p ? bus.rsp1_valid : bus.rsp0_valid) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsp_timeout: port %0d no rsp_valid", p);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [7:0] ops_a, ops_b;
  logic [7:0] ops_f[5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_rdy", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
    chk("rst_rspv", {30'd0, bus.rsp0_valid, bus.rsp1_valid}, 0);
    chk("rst_f", {24'd0, bus.rsp_f}, 0);
    chk("rst_gid", {31'd0, bus.grant_id}, 0);
    @(posedge clk);
    #1;

    // Port 0 add with carry, latency check.
    issue(0, 8'hF0, 8'h20, 3'b000, 8'h10, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_exec_v", {31'd0, bus.rsp0_valid}, 0);
    chk("lat_exec_busy", {31'd0, bus.busy}, 1);
    @(negedge clk);
    chk("lat_resp_v", {31'd0, bus.rsp0_valid}, 1);
    chk("lat_resp_v1", {31'd0, bus.rsp1_valid}, 0);
    repeat (2) @(posedge clk);
    #1;

    // Both ports always valid: alternate 0,1,0,1 every 3 cycles.
    do_reset();
    drive(0, 8'h01, 8'h02, 3'b000);
    drive(1, 8'hFF, 8'h0F, 3'b010);
    begin
      int cyc = 0;
      int last = 0;
      int k = 0;
      while (k < 4 && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (bus.req0_ready || bus.req1_ready) begin
          chk("alt_port", {31'd0, bus.req1_ready}, k % 2);
          if (k > 0) chk("alt_gap", cyc - last, 3);
          last = cyc;
          if (bus.req1_ready) push(1, 8'h0F, 1'b0, 1'b0);
          else                push(0, 8'h03, 1'b0, 1'b0);
          k++;
          if (k == 4) begin
            @(posedge clk);
            #1;
            bus.req0_valid = 0;
            bus.req1_valid = 0;
          end
        end
      end
      chk("alt_count", k, 4);
    end
    repeat (4) @(posedge clk);
    #1;

    // Compare ops on port 1.
    issue(1, 8'h5A, 8'h5A, 3'b110, 8'h00, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    issue(1, 8'h5A, 8'h5A, 3'b111, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure on port 0 with port 1 waiting.
    bus.rsp0_ready = 0;
    issue(0, 8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b0);
    drive(1, 8'h0F, 8'hF0, 3'b011);
    wait_rsp(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, bus.rsp0_valid}, 1);
      chk("bp_f", {24'd0, bus.rsp_f}, 32'h80);
      chk("bp_gid", {31'd0, bus.grant_id}, 0);
      chk("bp_req1_rdy", {31'd0, bus.req1_ready}, 0);
    end
    @(posedge clk);
    #1 bus.rsp0_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_done_busy", {31'd0, bus.busy}, 0);
    chk("bp_req1_go", {31'd0, bus.req1_ready}, 1);
    if (bus.req1_ready) push(1, 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.req1_valid = 0;
    repeat (3) @(posedge clk);
    #1;

    // Logic and shift ops on port 0.
    ops_a = 8'h81;
    ops_b = 8'h0F;
    ops_f[0] = 8'hF0;
    ops_f[1] = 8'h01;
    ops_f[2] = 8'h8F;
    ops_f[3] = 8'h40;
    ops_f[4] = 8'h02;
    for (int i = 0; i < 5; i++) begin
      logic [2:0] op;
      op = 3'(i + 1);
      issue(0, ops_a, ops_b, op, ops_f[i], 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
    end

    // Reset while a port 1 response is pending.
    bus.rsp1_ready = 0;
    issue(1, 8'hF0, 8'h20, 3'b000, 8'h10, 1'b1, 1'b0);
    wait_rsp(1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rr_rspv", {30'd0, bus.rsp0_valid, bus.rsp1_valid}, 0);
    chk("rr_busy", {31'd0, bus.busy}, 0);
    chk("rr_f", {24'd0, bus.rsp_f}, 0);
    chk("rr_ovf", {31'd0, bus.rsp_ovf}, 0);
    chk("rr_gid", {31'd0, bus.grant_id}, 0);
    bus.rsp1_ready = 1;
    @(posedge clk);
    #1;
    drive(0, 8'h10, 8'h20, 3'b011);
    drive(1, 8'h10, 8'h20, 3'b010);
    @(negedge clk);
    chk("rr_first_0", {30'd0, bus.req0_ready, bus.req1_ready}, 2);
    if (bus.req0_ready) push(0, 8'h30, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    repeat (6) @(posedge clk);

    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares one `eightbit_alu` instance between two requesters, such as the execute stage and a branch-compare unit. Each requester issues an operation (a, b, 3-bit op) over a valid/ready handshake. The block captures the operands, runs the ALU for one cycle, and returns a registered result to the winning port over a valid/ready response channel. ALU outputs are normalised per opcode, so responders never see stale or don't-care values.

## Interface
- `RR_INIT`, default 0: the port that has priority on the first arbitration after reset (0 or 1).
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: the port has an operation pending.
- `req0_ready` / `req1_ready` out 1: grant; a request is accepted on a cycle where valid && ready.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 8: operands.
- `req0_op`, `req1_op` in 3: ALU op code.
  - 000 add
  - 001 ~b
  - 010 and
  - 011 or
  - 100 a>>1 (logical)
  - 101 a<<1
  - 110 a==b
  - 111 a!=b
- `rsp0_valid` / `rsp1_valid` out 1: response available on that port.
- `rsp0_ready` / `rsp1_ready` in 1: the consumer takes the response.
- `rsp_f` out 8: result, shared by both ports and qualified by the per-port rsp valid.
- `rsp_ovf` out 1: carry-out of a+b; forced to 0 for every op except 000.
- `rsp_br` out 1: compare outcome for ops 110/111; forced to 0 for all other ops.
- `busy` out 1: high whenever state != IDLE.
- `grant_id` out 1: the port currently owning the ALU; holds its value while IDLE.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - `reqN_ready` is asserted combinationally for exactly one port: the winner among the valid ports.
  - If both ports are valid, the port that did not win last time wins.
  - If only one port is valid, it wins regardless of the pointer.
  - With no valid request, both ready outputs stay 0 and the FSM stays in IDLE.
  - On acceptance, register a, b, op and grant_id, then go to EXEC.
- EXEC:
  - The captured a, b and op drive the ALU.
  - Register the normalised outputs into `rsp_f` / `rsp_ovf` / `rsp_br`, then go to RESP.
  - For ops 110/111, `rsp_f` = 8'h00.
  - For ops 000–101, `rsp_br` = 0.
  - `rsp_f` is always an 8-bit wrap-around value; the carry appears only on `rsp_ovf`.
- RESP:
  - `rsp<grant_id>_valid` = 1; the other port's rsp_valid = 0.
  - The FSM holds, with outputs stable, until `rsp<grant_id>_ready` is high.
  - On the completing cycle, update the last-grant pointer to grant_id and return to IDLE.
- Both ready outputs are 0 in EXEC and RESP; a request cannot be accepted while the ALU is occupied.
- A requester must hold a, b and op stable while valid && !ready. The block does not check this.
- `rsp_ready` asserted while the corresponding rsp_valid is 0 is ignored.

## Timing
- Reset values:
  - state = IDLE
  - all ready and rsp_valid outputs = 0
  - `rsp_f` = 0, `rsp_ovf` = 0, `rsp_br` = 0
  - `busy` = 0
  - `grant_id` = RR_INIT
  - last-grant pointer = ~RR_INIT
- Latency: accept at edge T, EXEC during cycle T+1, rsp_valid high from cycle T+2.
- If rsp_ready is high in cycle T+2, the FSM is back in IDLE at T+3 and can accept again in that same cycle.
- Peak throughput is one operation per 3 cycles.
- Response backpressure extends RESP indefinitely. Results and grant_id stay stable throughout.
- Simultaneous valid from both ports in IDLE: exactly one ready is asserted, chosen per the pointer. The loser stays pending and wins the next arbitration if it is still valid.
- A new request arriving during EXEC or RESP waits. It is considered in the first IDLE cycle.
- `rst` in any state, including mid-EXEC or RESP with an undelivered response:
  - The in-flight operation is dropped.
  - All outputs return to their reset values on the next edge.
  - No rsp_valid is asserted for the dropped operation.

## Test plan
- Reset, then port 0 only, op 000, a=8'hF0, b=8'h20: req0_ready in IDLE; rsp0_valid 2 cycles after accept with f=8'h10, ovf=1, br=0; rsp1_valid stays 0.
- Both ports valid every cycle, rsp_ready tied 1, RR_INIT=0: grants alternate 0,1,0,1 with one accept every 3 cycles; never two readys in the same cycle.
- Port 1, op 110, a=b=8'h5A, then op 111 with the same operands: first response br=1, f=0, ovf=0; second br=0, f=0.
- Backpressure: hold rsp0_ready=0 for 5 cycles after rsp0_valid rises; valid, f and grant_id stay constant, req1 stays unaccepted, and completion occurs on the cycle rsp0_ready rises.
- Ops 001/010/011/100/101 with a=8'h81, b=8'h0F: f=8'hF0, 8'h01, 8'h8F, 8'h40, 8'h02 respectively; ovf=0 and br=0 for each.
- Assert rst during RESP: next cycle has rsp_valid=0, busy=0 and outputs at reset values; the next arbitration favours RR_INIT.
